// File: rtl/bus_result_monitor_pkg.sv
// Shared types and default constants for the bus result monitor and its benches.
package monitor_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT, ST_TIMEOUT} mon_state_t;

  localparam logic [15:0] DEF_RESULT_ADDR = 16'h0021;
  localparam logic [7:0]  DEF_EXPECT      = 8'h0C;
  localparam int          DEF_LOOP_COUNT  = 3;
  localparam int          DEF_TIMEOUT     = 1000;
endpackage

// File: rtl/bus_result_monitor_if.sv
// Snooped memory bus plus the monitor verdict; the bench is master, the monitor is slave.
interface bus_result_monitor_if;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  logic        fetch;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timed_out;
  logic [7:0]  result;
  logic        result_valid;
  logic [15:0] halt_pc;
  logic [15:0] cycles;

  modport master (
    output addr, wdata, we, fetch,
    input  done, pass, fail, timed_out, result, result_valid, halt_pc, cycles
  );
  modport slave (
    input  addr, wdata, we, fetch,
    output done, pass, fail, timed_out, result, result_valid, halt_pc, cycles
  );
endinterface

// File: rtl/fetch_loop_detector.sv
// Tracks the last opcode fetch address and how many times in a row it was fetched.
module fetch_loop_detector #(
  parameter int LOOP_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fetch_i,
  input  logic [15:0] addr_i,
  output logic        hit_o
);
  localparam logic [3:0] LC = 4'(LOOP_COUNT);

  logic [15:0] addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (en && fetch_i) begin
      if (cnt_q != 4'd0 && addr_i == addr_q) begin
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      end else begin
        cnt_d  = 4'd1;
        addr_d = addr_i;
      end
    end
  end

  // Combinational so the parent can register the verdict on the completing edge.
  assign hit_o = en && fetch_i && (cnt_d >= LC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/bus_result_monitor.sv
// Snoops writes and fetches, captures the result byte, and latches a pass/fail verdict
// on a jump-to-self loop or on watchdog expiry.
module bus_result_monitor
  import monitor_pkg::*;
#(
  parameter logic [15:0] RESULT_ADDR = DEF_RESULT_ADDR,
  parameter logic [7:0]  EXPECT      = DEF_EXPECT,
  parameter int          LOOP_COUNT  = DEF_LOOP_COUNT,
  parameter int          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                  ph2,
  input  logic                  resetb,
  bus_result_monitor_if.slave   bus
);
  localparam logic [15:0] TO_CYC = 16'(TIMEOUT);

  mon_state_t  state_q, state_d;
  logic        done_q, done_d, pass_q, pass_d, fail_q, fail_d, to_q, to_d;
  logic [7:0]  result_q, result_d;
  logic        rv_q, rv_d;
  logic [15:0] halt_pc_q, halt_pc_d, cycles_q, cycles_d;
  logic        active, capture, hit, pass_now;
  logic [15:0] cycles_inc;

  assign active = (state_q == ST_IDLE) || (state_q == ST_RUN);

  fetch_loop_detector #(.LOOP_COUNT(LOOP_COUNT)) u_det (
    .clk     (ph2),
    .rst_n   (resetb),
    .en      (active),
    .fetch_i (bus.fetch),
    .addr_i  (bus.addr),
    .hit_o   (hit)
  );

  assign capture    = active && bus.we && (bus.addr == RESULT_ADDR);
  assign cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;

  always_comb begin
    result_d  = capture ? bus.wdata : result_q;
    rv_d      = rv_q | capture;
    // Verdict sees a result write landing on the loop-completing cycle.
    pass_now  = rv_d && (result_d == EXPECT);
    state_d   = state_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    to_d      = to_q;
    halt_pc_d = halt_pc_q;
    cycles_d  = cycles_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.fetch) begin
          state_d  = ST_RUN;
          cycles_d = 16'd1;
        end
      end
      ST_RUN: begin
        cycles_d = cycles_inc;
        if (hit) begin
          state_d   = ST_HALT;
          done_d    = 1'b1;
          pass_d    = pass_now;
          fail_d    = !pass_now;
          halt_pc_d = bus.addr;
        end else if (cycles_inc >= TO_CYC) begin
          state_d = ST_TIMEOUT;
          done_d  = 1'b1;
          fail_d  = 1'b1;
          to_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      to_q      <= 1'b0;
      result_q  <= '0;
      rv_q      <= 1'b0;
      halt_pc_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      to_q      <= to_d;
      result_q  <= result_d;
      rv_q      <= rv_d;
      halt_pc_q <= halt_pc_d;
      cycles_q  <= cycles_d;
    end
  end

  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.fail         = fail_q;
  assign bus.timed_out    = to_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.halt_pc      = halt_pc_q;
  assign bus.cycles       = cycles_q;
endmodule

// File: tb/tb_bus_result_monitor.sv
// Directed scoreboard bench: each scenario queues its expected verdict, a monitor
// pops and compares it when done rises.
module tb_bus_result_monitor;
  import monitor_pkg::*;

  typedef struct {
    logic        done, pass, fail, to;
    logic [7:0]  result;
    logic        rv;
    logic [15:0] halt_pc, cycles;
  } exp_t;

  logic ph2 = 1'b0;
  logic resetb = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  bus_result_monitor_if bus();

  bus_result_monitor dut (
    .ph2    (ph2),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 ph2 = ~ph2;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic p, input logic to, input logic [7:0] r, input logic rv,
                      input logic [15:0] pc, input logic [15:0] cyc);
    exp_t e;
    e.done = 1'b1; e.pass = p; e.fail = !p; e.to = to;
    e.result = r; e.rv = rv; e.halt_pc = pc; e.cycles = cyc;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w, input logic f);
    bus.addr = a; bus.wdata = d; bus.we = w; bus.fetch = f;
    @(posedge ph2);
    #1;
  endtask

  task automatic idle();
    cyc(16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_done"}, bus.done, 0);
    cmp({tag, "_pass"}, bus.pass, 0);
    cmp({tag, "_fail"}, bus.fail, 0);
    cmp({tag, "_to"}, bus.timed_out, 0);
    cmp({tag, "_result"}, bus.result, 0);
    cmp({tag, "_rv"}, bus.result_valid, 0);
    cmp({tag, "_pc"}, bus.halt_pc, 0);
    cmp({tag, "_cycles"}, bus.cycles, 0);
  endtask

  task automatic pulse_reset();
    resetb = 1'b0;
    #3;
    resetb = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge ph2);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_no_done actual=pending expected=done", tag);
      sb.delete();
    end
  endtask

  // Loop at 0xF003 with an optional result write before it; done on the 6th edge.
  task automatic loop_test(input logic wr, input logic [7:0] val);
    cyc(16'hF000, 8'h00, 1'b0, 1'b1);
    if (wr) cyc(DEF_RESULT_ADDR, val, 1'b1, 1'b0);
    else    idle();
    cyc(16'hF001, 8'h00, 1'b0, 1'b1);
    cyc(16'hF003, 8'h00, 1'b0, 1'b1);
    cyc(16'hF003, 8'h00, 1'b0, 1'b1);
    cmp("early_done", bus.done, 0);
    cyc(16'hF003, 8'h00, 1'b0, 1'b1);
    idle();
  endtask

  // Monitor: compare the queued verdict on each rising edge of done.
  initial begin
    logic done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge ph2);
      if (resetb && bus.done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = sb.pop_front();
          cmp("done", bus.done, e.done);
          cmp("pass", bus.pass, e.pass);
          cmp("fail", bus.fail, e.fail);
          cmp("timed_out", bus.timed_out, e.to);
          cmp("result", bus.result, e.result);
          cmp("result_valid", bus.result_valid, e.rv);
          cmp("halt_pc", bus.halt_pc, e.halt_pc);
          cmp("cycles", bus.cycles, e.cycles);
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.addr = '0; bus.wdata = '0; bus.we = 1'b0; bus.fetch = 1'b0;
    repeat (2) @(posedge ph2);
    #1;
    chk_zero("reset");
    resetb = 1'b1;

    // Passing program
    push(1'b1, 1'b0, 8'h0C, 1'b1, 16'hF003, 16'd6);
    loop_test(1'b1, 8'h0C);
    drain("pass_loop");
    pulse_reset();

    // Wrong result value
    push(1'b0, 1'b0, 8'h0B, 1'b1, 16'hF003, 16'd6);
    loop_test(1'b1, 8'h0B);
    drain("bad_value");
    pulse_reset();

    // No result written
    push(1'b0, 1'b0, 8'h00, 1'b0, 16'hF003, 16'd6);
    loop_test(1'b0, 8'h00);
    drain("no_write");
    pulse_reset();

    // Watchdog: never repeat a fetch address
    push(1'b0, 1'b1, 8'h00, 1'b0, 16'h0000, 16'd1000);
    for (int i = 0; i < 1000; i++) cyc(16'h1000 + 16'(i), 8'h00, 1'b0, 1'b1);
    drain("timeout");
    repeat (3) cyc(16'h1000, 8'h00, 1'b0, 1'b1);
    cmp("timeout_frozen_cycles", bus.cycles, 16'd1000);
    cmp("timeout_frozen_done", bus.done, 1);
    pulse_reset();

    // Result write on the loop-completing fetch; later writes ignored
    push(1'b1, 1'b0, 8'h0C, 1'b1, 16'h0021, 16'd4);
    cyc(16'h0020, 8'h00, 1'b0, 1'b1);
    cyc(16'h0021, 8'h00, 1'b0, 1'b1);
    cyc(16'h0021, 8'h00, 1'b0, 1'b1);
    cyc(16'h0021, 8'h0C, 1'b1, 1'b1);
    drain("same_cycle_write");
    cyc(DEF_RESULT_ADDR, 8'h00, 1'b1, 1'b0);
    idle();
    cmp("post_halt_result", bus.result, 16'h000C);
    cmp("post_halt_cycles", bus.cycles, 16'd4);
    cmp("post_halt_pass", bus.pass, 1);
    pulse_reset();

    // Asynchronous reset mid-run
    cyc(16'hF000, 8'h00, 1'b0, 1'b1);
    cyc(DEF_RESULT_ADDR, 8'h0C, 1'b1, 1'b0);
    cyc(16'hF002, 8'h00, 1'b0, 1'b1);
    cmp("mid_run_cycles", bus.cycles, 16'd3);
    #2;
    resetb = 1'b0;
    #1;
    chk_zero("async_rst");
    #2;
    resetb = 1'b1;
    idle();
    cmp("idle_after_rst_cycles", bus.cycles, 16'd0);
    push(1'b0, 1'b0, 8'h00, 1'b0, 16'hF100, 16'd3);
    cyc(16'hF100, 8'h00, 1'b0, 1'b1);
    cmp("restart_cycles", bus.cycles, 16'd1);
    cyc(16'hF100, 8'h00, 1'b0, 1'b1);
    cyc(16'hF100, 8'h00, 1'b0, 1'b1);
    idle();
    drain("restart_loop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
